// File: rtl/mem_load_stage.sv
// -----------------------------------------------------------------------------
// mem_load_stage
// MEM stage of the in-order pipeline. Holds one instruction from EX and waits
// for its data response if it has one. The response is aligned and extended
// for the load op (lb/lbu/lh/lhu/lw/lwl/lwr) and passed to WB together with an
// opaque sideband. When WB stalls in the cycle the data arrives, the response
// goes into a one-entry skid buffer. After a flush, a discard counter drops
// data responses that are still in flight for squashed instructions.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   es_to_ms_valid      EX offers an instruction
//   ms_allowin          MEM accepts the EX instruction this cycle
//   es_op               load op (0 none,1 lb,2 lbu,3 lh,4 lhu,5 lw,6 lwl,7 lwr)
//   es_wait_data        a data response is owed to the offered instruction
//   es_req_pending      EX holds an unanswered request (used on flush only)
//   es_alu_result       load address or ALU result
//   es_rt_value         old rt value for the lwl/lwr merge
//   es_side             sideband payload carried through to WB
//   data_data_ok        one data response this cycle (in request order)
//   data_rdata          response data
//   flush               exception/eret flush from the commit point
//   ws_allowin          WB accepts
//   ms_to_ws_valid      result valid to WB
//   ms_result           final write-back value
//   ms_side             registered sideband
//   ms_busy             valid instruction still waiting for data
// -----------------------------------------------------------------------------
module mem_load_stage #(
  parameter int SIDE_W          = 40,
  parameter int MAX_OUTSTANDING = 3,
  parameter int DATA_W          = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [2:0]        es_op,
  input  logic              es_wait_data,
  input  logic              es_req_pending,
  input  logic [31:0]       es_alu_result,
  input  logic [31:0]       es_rt_value,
  input  logic [SIDE_W-1:0] es_side,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              flush,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_result,
  output logic [SIDE_W-1:0] ms_side,
  output logic              ms_busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_op;
  logic [31:0]       r_addr;
  logic [31:0]       r_rt;
  logic [SIDE_W-1:0] r_side;
  logic              r_skid_valid;
  logic [31:0]       r_skid_data;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_cnt_zero;
  logic              w_resp_live;   // response belongs to the held instruction
  logic              w_resp_drop;   // response belongs to a squashed instruction
  logic              w_wait_hit;
  logic              w_out_valid;
  logic              w_allowin;
  logic              w_capture;
  logic              w_skid_load;
  logic              w_flush_wait;
  logic              w_flush_pend;
  logic [CNT_W:0]    w_cnt_sum;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_resp_live = data_data_ok & w_cnt_zero;
  assign w_resp_drop = data_data_ok & ~w_cnt_zero;
  assign w_wait_hit  = (r_state == S_WAIT) & w_resp_live;
  // A flushed instruction never reaches WB, even on a zero-cycle bypass.
  assign w_out_valid = ~flush & ((r_state == S_READY) | w_wait_hit);
  assign w_allowin   = (r_state == S_EMPTY) | (w_out_valid & ws_allowin);
  assign w_capture   = es_to_ms_valid & w_allowin & ~flush;
  assign w_skid_load = ~flush & w_wait_hit & ~ws_allowin;

  // A flushed WAIT instruction still owes a response unless it arrives this
  // cycle; EX may also have one in flight. A dropped response retires one.
  assign w_flush_wait = flush & (r_state == S_WAIT) & ~w_resp_live;
  assign w_flush_pend = flush & es_req_pending;
  assign w_cnt_sum    = {1'b0, r_cnt}
                      + {{CNT_W{1'b0}}, w_flush_wait}
                      + {{CNT_W{1'b0}}, w_flush_pend}
                      - {{CNT_W{1'b0}}, w_resp_drop};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_WAIT:  if (w_resp_live) w_state_next = ws_allowin ? S_EMPTY : S_READY;
        S_READY: if (ws_allowin)  w_state_next = S_EMPTY;
        default: w_state_next = r_state;
      endcase
      if (w_capture) w_state_next = es_wait_data ? S_WAIT : S_READY;
    end
  end

  // Output logic
  always_comb begin
    ms_to_ws_valid = w_out_valid;
    ms_allowin     = w_allowin;
    ms_busy        = (r_state == S_WAIT) & ~w_resp_live;
  end

  // Instruction, skid buffer and discard counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= 3'd0;
      r_addr       <= 32'd0;
      r_rt         <= 32'd0;
      r_side       <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= 32'd0;
      r_cnt        <= '0;
    end else begin
      r_cnt <= w_cnt_sum[CNT_W-1:0];
      if (w_capture) begin
        r_op         <= es_op;
        r_addr       <= es_alu_result;
        r_rt         <= es_rt_value;
        r_side       <= es_side;
        r_skid_valid <= 1'b0;
      end else if (w_skid_load) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= data_rdata[31:0];
      end else if (flush) begin
        r_skid_valid <= 1'b0;
      end
    end
  end

  // Load alignment / extension
  logic [31:0] w_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_result;

  assign w_src  = r_skid_valid ? r_skid_data : data_rdata[31:0];
  assign w_half = r_addr[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    w_byte = w_src[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      2'd3:    w_byte = w_src[31:24];
      default: w_byte = w_src[7:0];
    endcase
  end

  always_comb begin
    w_result = r_addr;
    case (r_op)
      3'd1: w_result = {{24{w_byte[7]}}, w_byte};
      3'd2: w_result = {24'd0, w_byte};
      3'd3: w_result = {{16{w_half[15]}}, w_half};
      3'd4: w_result = {16'd0, w_half};
      3'd5: w_result = w_src;
      3'd6: begin
        // lwl: memory bytes fill from the top, rt keeps the low remainder
        case (r_addr[1:0])
          2'd0:    w_result = {w_src[7:0],  r_rt[23:0]};
          2'd1:    w_result = {w_src[15:0], r_rt[15:0]};
          2'd2:    w_result = {w_src[23:0], r_rt[7:0]};
          default: w_result = w_src;
        endcase
      end
      3'd7: begin
        // lwr: memory bytes fill from the bottom, rt keeps the high remainder
        case (r_addr[1:0])
          2'd1:    w_result = {r_rt[31:24], w_src[31:8]};
          2'd2:    w_result = {r_rt[31:16], w_src[31:16]};
          2'd3:    w_result = {r_rt[31:8],  w_src[31:24]};
          default: w_result = w_src;
        endcase
      end
      default: w_result = r_addr;
    endcase
  end

  assign ms_result = w_result;
  assign ms_side   = r_side;

  a_cnt_overflow: assert property (@(posedge clk) disable iff (reset)
    (w_cnt_sum <= MAX_CNT));
  a_stray_resp: assert property (@(posedge clk) disable iff (reset)
    !(data_data_ok && w_cnt_zero && (r_state != S_WAIT)));

endmodule
